// File: rtl/req_ack_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : req_ack_rr_arbiter
//  Purpose  : Round-robin arbiter that shares one start/done-pulse resource
//             among N_REQ requesters using a level req / pulse ack handshake.
//             One transaction is in flight at a time:
//             IDLE -> START -> WAIT -> ACK -> IDLE.
//  Ports    : clk          - single clock, all logic on posedge
//             rst_n        - asynchronous active-low reset
//             req_i        - level request, one bit per requester
//             req_data_i   - request payloads, slice i belongs to req_i[i]
//             ack_o        - one-cycle completion pulse (one-hot or zero)
//             ack_data_o   - response data, valid while ack_o != 0
//             ack_err_o    - timeout flag, valid while ack_o != 0
//             res_start_o  - one-cycle start pulse to the shared resource
//             res_data_o   - payload to the resource, valid with res_start_o
//             res_done_i   - one-cycle completion pulse from the resource
//             res_rdata_i  - resource result, valid with res_done_i
//  Options  : ARB_TIMEOUT_EN - when defined, WAIT is bounded to TIMEOUT
//             cycles; an expired wait completes with ack_err_o=1 and zero
//             data. When undefined, WAIT holds until res_done_i.
//  Revision : 1.0 - initial release
// ============================================================================
module req_ack_rr_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    output logic [N_REQ-1:0]        ack_o,
    output logic [DATA_W-1:0]       ack_data_o,
    output logic                    ack_err_o,
    output logic                    res_start_o,
    output logic [DATA_W-1:0]       res_data_o,
    input  logic                    res_done_i,
    input  logic [DATA_W-1:0]       res_rdata_i
);

    localparam int IDX_W = $clog2(N_REQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    // Pointer resets to the last index so requester 0 is scanned first.
    localparam logic [IDX_W-1:0] C_PTR_RST = IDX_W'(N_REQ - 1);
    localparam logic [IDX_W:0]   C_NREQ    = (IDX_W + 1)'(N_REQ);
    localparam logic [N_REQ-1:0] C_ONE     = N_REQ'(1);

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [DATA_W-1:0] ack_data_q, ack_data_d;
    logic              res_start_q, res_start_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;

    logic              w_found;
    logic [IDX_W-1:0]  w_win;
    logic [IDX_W:0]    w_sum;
    logic [IDX_W-1:0]  w_idx;
    logic              w_tmo;

    // Payload slices as an array so the winner can select one directly.
    logic [DATA_W-1:0] w_slice [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
        assign w_slice[gi] = req_data_i[gi*DATA_W +: DATA_W];
    end

    // Round-robin scan: ptr+1, ptr+2, ... wrapping modulo N_REQ. The one-bit
    // wider sum keeps the wrap correct for non power-of-two N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = ptr_q;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_sum = {1'b0, ptr_q} + (IDX_W + 1)'(k);
            if (w_sum >= C_NREQ) begin
                w_sum = w_sum - C_NREQ;
            end
            w_idx = w_sum[IDX_W-1:0];
            if (!w_found && req_i[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    // The counter reads 0 in the first WAIT cycle, so WAIT lasts TIMEOUT
    // cycles when the count equals TIMEOUT-1.
    localparam logic [CNT_W-1:0] C_TMO_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_err_q, ack_err_d;

    assign cnt_d = (state_q == S_WAIT) ? cnt_q + 1'b1 : '0;
    assign w_tmo = (state_q == S_WAIT) && (cnt_q == C_TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            ack_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            ack_err_q <= ack_err_d;
        end
    end

    assign ack_err_o = ack_err_q;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
    assign w_tmo            = 1'b0;
    assign ack_err_o        = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        ack_d       = '0;
        ack_data_d  = '0;
        res_start_d = 1'b0;
        res_data_d  = res_data_q;
`ifdef ARB_TIMEOUT_EN
        ack_err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    win_d       = w_win;
                    res_data_d  = w_slice[w_win];
                    res_start_d = 1'b1;
                    state_d     = S_START;
                end
            end
            S_START: begin
                // res_done_i here belongs to no transaction and is dropped.
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving with the timeout takes precedence.
                if (res_done_i) begin
                    ack_d      = C_ONE << win_q;
                    ack_data_d = res_rdata_i;
                    state_d    = S_ACK;
                end else if (w_tmo) begin
                    ack_d      = C_ONE << win_q;
`ifdef ARB_TIMEOUT_EN
                    ack_err_d  = 1'b1;
`endif
                    state_d    = S_ACK;
                end
            end
            S_ACK: begin
                ptr_d   = win_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= C_PTR_RST;
            win_q       <= '0;
            ack_q       <= '0;
            ack_data_q  <= '0;
            res_start_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            ack_q       <= ack_d;
            ack_data_q  <= ack_data_d;
            res_start_q <= res_start_d;
            res_data_q  <= res_data_d;
        end
    end

    assign ack_o       = ack_q;
    assign ack_data_o  = ack_data_q;
    assign res_start_o = res_start_q;
    assign res_data_o  = res_data_q;

endmodule
`default_nettype wire

// File: tb/tb_req_ack_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_req_ack_rr_arbiter
//  Purpose  : Directed self-checking bench for req_ack_rr_arbiter. Expected
//             acks are queued when each grant starts and retired by a monitor
//             when the DUT pulses ack. Timeout cases build only when
//             ARB_TIMEOUT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_req_ack_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 8;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  ack;
    logic [DW-1:0] ack_data;
    logic          ack_err;
    logic          res_start;
    logic [DW-1:0] res_data;
    logic          res_done;
    logic [DW-1:0] res_rdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t;
    int a;
    bit seen4;

    typedef struct {
        logic [N-1:0]  vec;
        logic [DW-1:0] data;
        logic          err;
        int            cyc;
    } sb_t;

    sb_t sb[$];

    req_ack_rr_arbiter #(
        .N_REQ   (N),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req),
        .req_data_i  (req_data),
        .ack_o       (ack),
        .ack_data_o  (ack_data),
        .ack_err_o   (ack_err),
        .res_start_o (res_start),
        .res_data_o  (res_data),
        .res_done_i  (res_done),
        .res_rdata_i (res_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack))
        else begin
            bad++;
            $error("FAIL ack_onehot0 observed=%b", ack);
        end

    a_start_pulse: assert property (@(posedge clk) disable iff (!rst_n) res_start |=> !res_start)
        else begin
            bad++;
            $error("FAIL res_start_pulse observed two-cycle start");
        end

    // Ack monitor: every ack pulse must match the oldest queued expectation.
    always @(negedge clk) begin : mon
        sb_t e;
        if (rst_n && ack !== '0) begin
            if (sb.size() == 0) begin
                chk("ack_unexpected", ack, 0);
            end else begin
                e = sb.pop_front();
                chk("ack_vec", ack, e.vec);
                chk("ack_data", ack_data, e.data);
                chk("ack_err", ack_err, e.err);
                chk("ack_cyc", cyc, e.cyc);
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_ack_data"}, ack_data, 0);
        chk({tag, "_ack_err"}, ack_err, 0);
        chk({tag, "_res_start"}, res_start, 0);
        chk({tag, "_res_data"}, res_data, 0);
    endtask

    // Serve one grant: wait for res_start, queue the expected ack, then answer
    // after lat cycles (or stay silent to provoke a timeout).
    task automatic grant(input int idx, input int exp_start, input int lat,
                         input bit respond, input bit early,
                         input bit chg, input logic [N-1:0] req_w);
        bit            seen;
        logic [DW-1:0] pay;
        int            s;
        sb_t           e;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (res_start === 1'b1) seen = 1'b1;
        end
        chk("start_seen", seen, 1);
        if (!seen) return;
        s   = cyc;
        pay = req_data[idx*DW +: DW];
        chk("start_cyc", s, exp_start);
        chk("res_data", res_data, pay);
        e.vec  = N'(1) << idx;
        e.data = respond ? ~pay : '0;
        e.err  = respond ? 1'b0 : 1'b1;
        e.cyc  = s + lat + 1;
        sb.push_back(e);
        if (early) begin
            res_done  = 1'b1;
            res_rdata = 8'hEE;
        end
        for (int i = 1; i <= lat; i++) begin
            @(posedge clk);
            #1;
            res_done = 1'b0;
            if (i == 1 && chg) req = req_w;
            if (i == lat && respond) begin
                res_done  = 1'b1;
                res_rdata = ~pay;
            end
        end
        @(posedge clk);
        #1;
        res_done = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        req_data  = '0;
        res_done  = 1'b0;
        res_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request, minimum latency.
        req_data = 32'h4433_225A;
        req      = 4'b0001;
        t        = cyc;
        grant(0, t + 1, 1, 1'b1, 1'b0, 1'b0, '0);
        req = '0;
        repeat (3) @(posedge clk);
        #1;

        // All requesting: 0,1,2,3,0 spaced by four cycles.
        do_reset();
        req_data = 32'h4433_2211;
        req      = 4'b1111;
        t        = cyc;
        for (int k = 0; k < 5; k++) begin
            grant(k % N, t + 1 + 4 * k, 1, 1'b1, 1'b0, 1'b0, '0);
        end
        req = '0;
        repeat (3) @(posedge clk);
        #1;

        // Grant to 2, req[2] drops and req[0] rises during WAIT; 3 is next.
        req_data = 32'hD4C3_B2A1;
        req      = 4'b1100;
        t        = cyc;
        grant(2, t + 1, 3, 1'b1, 1'b0, 1'b1, 4'b1001);
        a = cyc;
        grant(3, a + 2, 1, 1'b1, 1'b0, 1'b0, '0);
        req = 4'b0001;
        a   = cyc;
        grant(0, a + 2, 2, 1'b1, 1'b0, 1'b0, '0);
        req = '0;
        repeat (3) @(posedge clk);
        #1;

        // Asynchronous reset in WAIT drops the transaction.
        req_data = 32'h1E2D_3C4B;
        req      = 4'b0010;
        seen4    = 1'b0;
        for (int i = 0; i < 40 && !seen4; i++) begin
            @(negedge clk);
            if (res_start === 1'b1) seen4 = 1'b1;
        end
        chk("t4_start_seen", seen4, 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        req   = '0;
        #1;
        chk_zero_outputs("async_rst");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Stale completion in IDLE must not produce an ack.
        res_done  = 1'b1;
        res_rdata = 8'h77;
        @(posedge clk);
        #1;
        res_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stale_no_ack", ack, 0);
        // Served normally after reset; a done in the START cycle is ignored.
        req = 4'b1000;
        t   = cyc;
        grant(3, t + 1, 2, 1'b1, 1'b1, 1'b0, '0);
        req = '0;
        repeat (3) @(posedge clk);
        #1;

`ifdef ARB_TIMEOUT_EN
        // Resource never answers: ack with error after TO WAIT cycles.
        req = 4'b0100;
        t   = cyc;
        grant(2, t + 1, TO, 1'b0, 1'b0, 1'b0, '0);
        req = '0;
        repeat (3) @(posedge clk);
        #1;
        // Done coincides with the timeout: done wins.
        req = 4'b0001;
        t   = cyc;
        grant(0, t + 1, TO, 1'b1, 1'b0, 1'b0, '0);
        req = '0;
        repeat (3) @(posedge clk);
        #1;
`endif

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
